// File: rtl/spi_master_xfer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_master_xfer                                              |
// | Description : Single-clock SPI initiator, mode 1 (CPOL=0, CPHA=1). Runs    |
// |               one full-duplex DATA_W-bit transfer per accepted start.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Parameters                                                                 |
// |   DATA_W   word length in bits (>= 2)                                      |
// |   CLK_DIV  clk cycles per SCLK half-period (>= 1)                          |
// | Ports                                                                      |
// |   clk      in   system clock                                               |
// |   rst      in   synchronous reset, active-high                             |
// |   start    in   transfer request, accepted only while busy = 0             |
// |   tx_data  in   word to send, captured on the accepting cycle              |
// |   busy     out  transfer in progress                                       |
// |   done     out  one-cycle pulse when rx_data is updated                    |
// |   rx_data  out  last received word                                         |
// |   sclk     out  SPI clock, idles low                                       |
// |   cs_n     out  chip select, active-low                                    |
// |   mosi     out  serial data out                                            |
// |   miso     in   serial data in                                             |
// | Build option                                                               |
// |   SPI_MASTER_LSB_FIRST_EN  defined: LSB first on mosi and miso;            |
// |                            undefined (default): MSB first.                 |
// +----------------------------------------------------------------------------+
module spi_master_xfer #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int c_DIV_W = $clog2(CLK_DIV + 1);
  localparam int c_BIT_W = $clog2(DATA_W + 1);

  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t              state_q,   state_d;
  logic [c_DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [c_BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   tx_sh_q,   tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q,   rx_sh_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                sclk_q,    sclk_d;
  logic                cs_n_q,    cs_n_d;
  logic                mosi_q,    mosi_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;

  // Bit-order dependent shift paths: the bit to present next on mosi, the
  // transmit register after that bit leaves, and the receive register after
  // miso is shifted in.
  logic                w_tx_bit;
  logic [DATA_W-1:0]   w_tx_next;
  logic [DATA_W-1:0]   w_rx_next;
  logic                w_div_end;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign w_tx_bit  = tx_sh_q[0];
  assign w_tx_next = {1'b0, tx_sh_q[DATA_W-1:1]};
  assign w_rx_next = {miso, rx_sh_q[DATA_W-1:1]};
`else
  assign w_tx_bit  = tx_sh_q[DATA_W-1];
  assign w_tx_next = {tx_sh_q[DATA_W-2:0], 1'b0};
  assign w_rx_next = {rx_sh_q[DATA_W-2:0], miso};
`endif

  // Every timed phase (SETUP, each SCLK half-period, HOLD) lasts CLK_DIV
  // cycles; the divider restarts from zero at each phase boundary.
  assign w_div_end = (div_cnt_q == c_DIV_LAST);

  // All outputs are computed one cycle ahead and registered, so sclk, cs_n
  // and mosi come straight from flops.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      // DONE behaves like IDLE for request acceptance, which gives
      // back-to-back transfers with a single cs_n-high cycle between them.
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          state_d   = ST_SETUP;
          tx_sh_d   = tx_data;
          rx_sh_d   = '0;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
        end
      end

      ST_SETUP: begin
        if (w_div_end) begin
          // End of the select setup time: first rising edge, first bit out.
          div_cnt_d = '0;
          state_d   = ST_SHIFT;
          sclk_d    = 1'b1;
          mosi_d    = w_tx_bit;
          tx_sh_d   = w_tx_next;
        end else begin
          div_cnt_d = div_cnt_q + c_DIV_W'(1);
        end
      end

      ST_SHIFT: begin
        if (w_div_end) begin
          div_cnt_d = '0;
          if (sclk_q) begin
            // Falling edge: capture miso as it stood during the high phase.
            sclk_d    = 1'b0;
            rx_sh_d   = w_rx_next;
            bit_cnt_d = bit_cnt_q + c_BIT_W'(1);
          end else if (bit_cnt_q == c_BIT_LAST) begin
            // Low phase of the last period is complete.
            state_d = ST_HOLD;
            mosi_d  = 1'b0;
          end else begin
            sclk_d  = 1'b1;
            mosi_d  = w_tx_bit;
            tx_sh_d = w_tx_next;
          end
        end else begin
          div_cnt_d = div_cnt_q + c_DIV_W'(1);
        end
      end

      ST_HOLD: begin
        if (w_div_end) begin
          div_cnt_d = '0;
          state_d   = ST_DONE;
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
        end else begin
          div_cnt_d = div_cnt_q + c_DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;

endmodule
`default_nettype wire

// File: doc/spi_master_xfer.md
# spi_master_xfer

Single-clock SPI initiator that generates `sclk`, `cs_n` and `mosi` and samples `miso`, performing one full-duplex word transfer per `start` request. It is the controller-side counterpart of the team's SPI slave blocks and serves as the on-chip bench driver. It also drives external SPI targets from the `ui_in`/`uo_out` pins of the user wrapper.

## Interface
Parameters:
- `DATA_W`, 8, word length in bits (≥2)
- `CLK_DIV`, 2, `clk` cycles per SCLK half-period (≥1)

Ports:
- `clk`  in  1  system clock; one clock; reset is synchronous and active-high
- `rst`  in  1  synchronous reset, active-high
- `start`  in  1  transfer request; accepted only when `busy`=0
- `tx_data`  in  DATA_W  word to send; captured on the accepting cycle
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle pulse when `rx_data` is updated
- `rx_data`  out  DATA_W  last received word
- `sclk`  out  1  SPI clock; idles low (CPOL=0)
- `cs_n`  out  1  chip select, active-low
- `mosi`  out  1  serial data out
- `miso`  in  1  serial data in

## Operation
- Protocol: CPOL=0, CPHA=1 (SPI mode 1).
  - `mosi` changes on SCLK rising edges.
  - The target samples `mosi` on falling edges.
  - The master samples `miso` on falling edges.
- States: IDLE → SETUP → SHIFT → HOLD → DONE → IDLE.
- **IDLE:** `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0.
  - When `start`=1: latch `tx_data` into the shift register, clear the bit counter, go to SETUP.
- **SETUP:** `cs_n`=0, `sclk`=0, lasting CLK_DIV cycles.
- **SHIFT:** DATA_W SCLK periods. Each period is CLK_DIV cycles high followed by CLK_DIV cycles low.
  - On each rising edge: `mosi` takes the next tx bit.
  - On each falling edge: `miso` is shifted into the rx register.
  - The bit counter increments on each falling edge; after falling edge DATA_W, go to HOLD.
- **HOLD:** `cs_n`=0, `sclk`=0, `mosi`=0, lasting CLK_DIV cycles.
- **DONE:** one cycle.
  - `cs_n`=1, `done`=1, `busy`=0.
  - `rx_data` is loaded from the rx register.
  - A `start` seen in this cycle is accepted (back-to-back operation).
- `rx_data` holds its value until the next `done`.
- `start` while `busy`=1 is ignored and is not queued.
- `tx_data` changes after the accepting cycle do not affect the transfer in progress.

## Timing
- Reset values: `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0; state=IDLE.
- Reset mid-transfer: every output returns to its reset value on the next edge, and no `done` is produced.
- Let cycle 0 be the edge that samples `start`=1.
  - `busy`=1 and `cs_n`=0 from cycle 1.
  - First `sclk` rise at cycle 1+CLK_DIV.
  - `done` at cycle 1+2·CLK_DIV·(DATA_W+1).
  - Defaults (CLK_DIV=2, DATA_W=8): 37 cycles.
- `cs_n` is high for at least one cycle between back-to-back transfers.
- `sclk`, `cs_n` and `mosi` are register outputs (glitch-free).
- `miso` is sampled with the `clk` edge that drives `sclk` low. The falling-edge sample uses `miso` as seen in the last cycle of the high phase.
- Counter widths: division counter ⌈log2(CLK_DIV+1)⌉ bits; bit counter ⌈log2(DATA_W+1)⌉ bits. No wrap-around is permitted within a transfer.

## Configuration
- Macro `SPI_MASTER_LSB_FIRST_EN`.
  - Undefined (default): MSB first. `tx_data[DATA_W-1]` goes out first, and the first received bit lands in `rx_data[DATA_W-1]`.
  - Defined: LSB first on both `mosi` and `miso`. `tx_data[0]` goes out first, and the first received bit lands in `rx_data[0]`.
- Timing is identical in both builds.

## Test plan
- Reset: hold `rst`=1 for 3 cycles mid-SHIFT → `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0, `rx_data`=0x00, no `done`.
- Basic transfer (defaults): `tx_data`=0xA5, slave model returns 0x3C → `mosi` bit sequence 1,0,1,0,0,1,0,1; exactly 8 `sclk` rises; `done` at cycle 37; `rx_data`=0x3C.
- Back-to-back: assert `start` with 0x01 during the DONE cycle → new `cs_n` low at DONE+1 after exactly one `cs_n`-high cycle; second `rx_data` correct.
- Busy ignore: pulse `start` with 0xFF at cycle 10 of a 0x00 transfer → `mosi` stays 0 for all bits; only one `done` is produced.
- Divider: CLK_DIV=1, DATA_W=8, `tx_data`=0x81 → `sclk` period 2 cycles; `done` at cycle 19.
- LSB build: with `SPI_MASTER_LSB_FIRST_EN` defined, `tx_data`=0x01 → first `mosi` bit is 1; slave sends 1,0,0,0,0,0,0,0 → `rx_data`=0x01.
